hgcal_latent_unpacker: RTL and testbench
========================================

# hgcal_latent_unpacker

Decoder-side receiver for the HGCAL autoencoder latent link. Accepts the 2-bit quantized latent codes emitted by the encoder's final LUT layer, streamed LANES codes per beat, and reassembles them into one full latent frame. Each code is dequantized to a signed fixed-point value and presented in parallel to the first decoder layer over a valid/ready handshake. It is the read end of the code stream the encoder neurons write.

## Interface
- CODE_W, 2: bits per latent code (quantized activation width).
- LATENT, 16: codes per frame; must be a multiple of LANES.
- LANES, 4: codes per input beat.
- DQ_W, 8: width of each dequantized signed output value.
- clk  in  1: single clock; all state on rising edge.
- rst_n  in  1: reset, asynchronous assert, active-low.
- s_valid  in  1: input beat valid.
- s_ready  out  1: unpacker can accept a beat.
- s_data  in  LANES*CODE_W: lane i holds a code at bits [i*CODE_W +: CODE_W].
- s_last  in  1: marks the final beat of a frame.
- m_valid  out  1: latent frame valid.
- m_ready  in  1: decoder accepts the frame.
- m_data  out  LATENT*DQ_W: value for code k at bits [k*DQ_W +: DQ_W], two's complement.
- err  out  1: sticky framing error.
- err_clr  in  1: synchronous clear of err.

## Operation
- BEATS = LATENT/LANES. beat_cnt runs 0..BEATS-1 and increments on each accepted beat (s_valid && s_ready).
- Code index mapping: beat b, lane i maps to k = b*LANES + i. Codes are held raw in a collect buffer of LATENT*CODE_W bits.
- Dequantization is a fixed map applied when the frame moves to the output register:
  - 2'b00 maps to -96 (8'hA0).
  - 2'b01 maps to -32 (8'hE0).
  - 2'b10 maps to +32 (8'h20).
  - 2'b11 maps to +96 (8'h60).
  - Values are sign-extended or truncated to DQ_W. The LSB of a DQ_W=8 value is 1/64.
- States:
  - COLLECT: beat_cnt < BEATS-1.
  - LAST: beat_cnt == BEATS-1.
- s_ready rule:
  - In COLLECT, s_ready = 1.
  - In LAST, s_ready = !m_valid || m_ready. The frame can only complete into a free or simultaneously drained output register.
- Frame completion: when the beat at beat_cnt == BEATS-1 is accepted, the full dequantized frame (including the current beat) loads into m_data, m_valid is set, and beat_cnt returns to 0.
- When m_valid && m_ready, m_valid clears, unless a new frame loads in the same cycle, in which case m_valid stays 1 and m_data takes the new frame.
- m_data is held stable while m_valid && !m_ready.
- Output back-pressure never stalls beats 0..BEATS-2 of the next frame.

## Timing
- Reset values: m_valid=0, m_data=0, err=0, beat_cnt=0, collect buffer=0. s_ready evaluates to 1 out of reset.
- Latency: last beat accepted at edge t gives m_valid=1 and m_data valid after edge t; visible in cycle t+1.
- Throughput: one beat per cycle sustained, one frame per BEATS cycles, as long as m_ready is held high.
- Reset asserted mid-frame: the partial frame is discarded and an unconsumed output frame is lost. After release, the first accepted beat is beat 0.
- err_clr and a new error in the same cycle: err ends at 1 (set wins).

## Configuration
- HGCAL_UNPACK_ALIGN_CHECK_EN defined:
  - s_last asserted on an accepted beat with beat_cnt != BEATS-1: err is set, the partial frame is dropped, beat_cnt goes to 0, and no m_valid is generated.
  - s_last deasserted on an accepted beat with beat_cnt == BEATS-1: err is set, but the frame is still emitted normally.
- Not defined: s_last is ignored, err is tied to 0, err_clr is unused, and framing relies on beat_cnt alone.

## Test plan
- Basic frame: after reset, 4 beats of s_data=8'b11_10_01_00 with s_last on beat 3 and m_ready=1. Required: m_valid for 1 cycle, one cycle after beat 3, with m_data repeating {60,20,E0,A0} per group of 4 codes (code 0 = A0).
- Back-pressure: m_ready=0, stream 2 frames back-to-back. Required: beats 0-2 of frame 2 are accepted; s_ready=0 at beat 3; frame 1 stays stable. Then raise m_ready: frame 2 loads in the same cycle frame 1 drains, and m_valid stays 1.
- Full rate: 8 consecutive frames with s_valid=1 and m_ready=1. Required: s_ready never drops, and m_valid pulses every 4th cycle.
- Early s_last (macro on): s_last on beat 1. Required: err=1, no m_valid, and the next 4-beat frame is emitted correctly. Pulsing err_clr returns err to 0.
- Missing s_last (macro on): beat 3 sent without s_last. Required: frame emitted and err=1. With the macro off, the same stimulus gives err=0.
- Reset mid-frame: assert rst_n=0 after beat 2, then release and send a full frame. Required: only that frame is emitted, and its values match the codes sent after reset.

Source files
------------

// File: rtl/hgcal_latent_unpacker.sv
// hgcal_latent_unpacker: collects LANES 2-bit latent codes per beat into a
// LATENT-code frame, dequantizes each code to a signed DQ_W value and hands
// the frame to the decoder over a valid/ready handshake.
// Optional feature macro: HGCAL_UNPACK_ALIGN_CHECK_EN enables s_last framing
// checks and the sticky err flag; without it s_last/err_clr are ignored and
// err is tied low.
module hgcal_latent_unpacker #(
   parameter int CODE_W = 2,
   parameter int LATENT = 16,
   parameter int LANES  = 4,
   parameter int DQ_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [LANES*CODE_W-1:0]  s_data,
   input  logic                     s_last,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [LATENT*DQ_W-1:0]   m_data,
   output logic                     err,
   input  logic                     err_clr
);

   localparam int BEATS     = LATENT / LANES;
   localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BEAT_BITS = LANES * CODE_W;
   localparam int BUF_W     = LATENT * CODE_W;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   // Collection phase is fully determined by the beat counter.
   typedef enum logic {
      COLLECT = 1'b0,
      LAST    = 1'b1
   } phase_e;

   logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic [BUF_W-1:0]       buf_q, buf_d;
   logic                   m_valid_q, m_valid_d;
   logic [LATENT*DQ_W-1:0] m_data_q, m_data_d;

   phase_e                 phase;
   logic                   accept;
   logic                   frame_done;
   logic                   early_last;
   logic                   missing_last;
   logic [BUF_W-1:0]       frame_codes;
   logic [LATENT*DQ_W-1:0] dq_frame;

   // Fixed code-to-value map; 1 LSB = 1/64 at DQ_W = 8.
   function automatic logic [DQ_W-1:0] dequant(input logic [1:0] code);
      case (code)
         2'b00:   dequant = DQ_W'(-96);
         2'b01:   dequant = DQ_W'(-32);
         2'b10:   dequant = DQ_W'(32);
         default: dequant = DQ_W'(96);
      endcase
   endfunction

   assign phase   = (beat_cnt_q == LAST_BEAT) ? LAST : COLLECT;
   // The last beat may only land when the output register is free or draining.
   assign s_ready = (phase == LAST) ? (!m_valid_q || m_ready) : 1'b1;
   assign accept  = s_valid && s_ready;

`ifdef HGCAL_UNPACK_ALIGN_CHECK_EN
   assign early_last   = accept && s_last && (phase == COLLECT);
   assign missing_last = accept && !s_last && (phase == LAST);
`else
   assign early_last   = 1'b0;
   assign missing_last = 1'b0;
`endif

   assign frame_done = accept && (phase == LAST);

   // Overlay the in-flight beat onto the buffer and dequantize the whole frame.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      frame_codes = buf_q;
      frame_codes[int'(beat_cnt_q)*BEAT_BITS +: BEAT_BITS] = s_data;
      dq_frame = '0;
      for (int k = 0; k < LATENT; k++) begin
         dq_frame[k*DQ_W +: DQ_W] = dequant(frame_codes[k*CODE_W +: 2]);
      end
   end

   // Next-state for beat counter, collect buffer and output register.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      buf_d      = buf_q;
      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;

      if (accept) begin
         buf_d = frame_codes;
         if (frame_done || early_last) begin
            beat_cnt_d = '0;
         end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
         end
      end

      if (frame_done) begin
         m_valid_d = 1'b1;
         m_data_d  = dq_frame;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_q <= '0;
         // NOTE: the collect buffer is reset even though it is data storage,
         // so a frame after reset never carries stale codes.
         buf_q      <= '0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         beat_cnt_q <= beat_cnt_d;
         buf_q      <= buf_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;

`ifdef HGCAL_UNPACK_ALIGN_CHECK_EN
   logic err_q, err_d;

   // Sticky framing error; a new error wins over a simultaneous clear.
   always_comb begin
      err_d = (err_q && !err_clr) || early_last || missing_last;
   end

   // Error flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_framing;
   assign unused_framing = &{1'b0, s_last, err_clr, early_last, missing_last};
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hgcal_latent_unpacker.sv
// Scoreboard bench for hgcal_latent_unpacker: a beat-level model pushes
// expected frames into a queue, and a monitor compares them when m_valid is up.
// Works with and without HGCAL_UNPACK_ALIGN_CHECK_EN.
module tb_hgcal_latent_unpacker;

   localparam int CODE_W = 2;
   localparam int LATENT = 16;
   localparam int LANES  = 4;
   localparam int DQ_W   = 8;
   localparam int BEATS  = LATENT / LANES;
   localparam int FW     = LATENT * DQ_W;
   localparam int BW     = LANES * CODE_W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   logic [BW-1:0] s_data;
   logic          s_last;
   logic          m_valid;
   logic          m_ready;
   logic [FW-1:0] m_data;
   logic          err;
   logic          err_clr;

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            pops = 0;
   int            stall_cnt = 0;
   int            gap_prev = -1;
   bit            gap_mode = 0;
   bit            rand_mode = 0;
   bit            exp_err = 0;
   logic [FW-1:0] exp_q[$];
   int            codes[$];

   hgcal_latent_unpacker #(
      .CODE_W(CODE_W), .LATENT(LATENT), .LANES(LANES), .DQ_W(DQ_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .err(err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: compare the presented frame with the scoreboard head; pop on handshake.
   always @(negedge clk) begin
      if (rst_n && m_valid) begin
         check("frame_expected", FW'(exp_q.size() > 0), FW'(1));
         if (exp_q.size() > 0) begin
            check("m_data", m_data, exp_q[0]);
            if (m_ready) begin
               void'(exp_q.pop_front());
               pops++;
               if (gap_mode) begin
                  if (gap_prev >= 0) check("frame_gap", FW'(cyc - gap_prev), FW'(BEATS));
                  gap_prev = cyc;
               end
            end
         end
      end
   end

   // Reference model: codes in arrival order; value = 64*code - 96 (units of 1/64).
   task automatic model_beat(input logic [BW-1:0] data, input bit last);
      bit            new_err;
      logic [FW-1:0] f;
      int            v;
      new_err = 0;
      for (int i = 0; i < LANES; i++) codes.push_back(int'(data[i*CODE_W +: CODE_W]));
`ifdef HGCAL_UNPACK_ALIGN_CHECK_EN
      if (last && codes.size() < LATENT) begin
         new_err = 1;
         codes.delete();
      end else if (!last && codes.size() == LATENT) begin
         new_err = 1;
      end
      exp_err = (exp_err && !err_clr) || new_err;
`endif
      if (codes.size() == LATENT) begin
         f = '0;
         for (int k = 0; k < LATENT; k++) begin
            v = 64 * codes[k] - 96;
            f[k*DQ_W +: DQ_W] = DQ_W'(v);
         end
         exp_q.push_back(f);
         codes.delete();
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      if (rand_mode) m_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
`ifdef HGCAL_UNPACK_ALIGN_CHECK_EN
         if (err_clr) exp_err = 0;
`endif
         next_cycle();
      end
   endtask

   task automatic send_beat(input logic [BW-1:0] data, input bit last);
      bit done;
      int budget;
      done = 0;
      budget = 0;
      s_valid = 1'b1;
      s_data = data;
      s_last = last;
      while (!done) begin
         @(negedge clk);
         if (s_ready) begin
            model_beat(data, last);
            done = 1;
         end else begin
            stall_cnt++;
         end
         next_cycle();
         budget++;
         if (!done && budget > 200) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout: got no s_ready expected s_ready within 200 cycles");
            break;
         end
      end
      s_valid = 1'b0;
      s_last = 1'b0;
   endtask

   // Complete the model's partial frame with correctly framed beats.
   task automatic flush_partial();
      while (codes.size() != 0) send_beat(BW'($urandom), codes.size() == LATENT - LANES);
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      check("err_cleared", FW'(err), FW'(exp_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int p0;
      int w;
      logic [BW-1:0] d;

      rst_n = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      s_last = 1'b0;
      m_ready = 1'b0;
      err_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_m_valid", FW'(m_valid), FW'(0));
      check("reset_m_data", m_data, '0);
      check("reset_err", FW'(err), FW'(0));
      check("reset_s_ready", FW'(s_ready), FW'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // Basic frame with a fixed code pattern.
      m_ready = 1'b1;
      for (int b = 0; b < BEATS; b++) send_beat(8'b11_10_01_00, b == BEATS - 1);
      check("basic_valid", FW'(m_valid), FW'(1));
      check("basic_literal", m_data, {4{32'h6020_E0A0}});
      idle(1);
      check("basic_valid_pulse", FW'(m_valid), FW'(0));

      // Back-pressure: frame 1 held, frame 2 beats 0..2 accepted, beat 3 stalls.
      m_ready = 1'b0;
      for (int b = 0; b < BEATS; b++) send_beat(BW'($urandom), b == BEATS - 1);
      stall_cnt = 0;
      for (int b = 0; b < BEATS - 1; b++) send_beat(BW'($urandom), 1'b0);
      check("bp_no_early_stall", FW'(stall_cnt), FW'(0));
      d = BW'($urandom);
      s_valid = 1'b1;
      s_data = d;
      s_last = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bp_s_ready_low", FW'(s_ready), FW'(0));
         check("bp_m_valid_held", FW'(m_valid), FW'(1));
         next_cycle();
      end
      m_ready = 1'b1;
      send_beat(d, 1'b1);
      check("bp_swap_valid", FW'(m_valid), FW'(1));
      idle(2);
      check("bp_drained", FW'(exp_q.size()), FW'(0));

      // Full rate: 8 frames back to back.
      stall_cnt = 0;
      gap_prev = -1;
      gap_mode = 1;
      c0 = cyc;
      p0 = pops;
      for (int b = 0; b < 8 * BEATS; b++) send_beat(BW'($urandom), (b % BEATS) == BEATS - 1);
      check("full_rate_cycles", FW'(cyc - c0), FW'(8 * BEATS));
      check("full_rate_stalls", FW'(stall_cnt), FW'(0));
      idle(2);
      gap_mode = 0;
      check("full_rate_frames", FW'(pops - p0), FW'(8));

      // Early s_last on beat 1, then a clean frame.
      p0 = pops;
      send_beat(BW'($urandom), 1'b0);
      send_beat(BW'($urandom), 1'b1);
      idle(1);
      check("early_err", FW'(err), FW'(exp_err));
      check("early_no_valid", FW'(m_valid), FW'(0));
      flush_partial();
      for (int b = 0; b < BEATS; b++) send_beat(BW'($urandom), b == BEATS - 1);
      idle(2);
      check("early_recovery_drained", FW'(exp_q.size()), FW'(0));
      clear_err();

      // New error and clear in the same cycle: set wins.
      err_clr = 1'b1;
      send_beat(BW'($urandom), 1'b1);
      err_clr = 1'b0;
      check("set_wins", FW'(err), FW'(exp_err));
      flush_partial();
      clear_err();

      // Missing s_last on beat 3: frame still emitted.
      p0 = pops;
      for (int b = 0; b < BEATS; b++) send_beat(BW'($urandom), 1'b0);
      idle(2);
      check("missing_err", FW'(err), FW'(exp_err));
      check("missing_frame", FW'(pops - p0), FW'(1));
      clear_err();

      // Reset mid-frame with an unconsumed output frame pending.
      m_ready = 1'b0;
      for (int b = 0; b < BEATS; b++) send_beat(BW'($urandom), b == BEATS - 1);
      for (int b = 0; b < BEATS - 1; b++) send_beat(BW'($urandom), 1'b0);
      rst_n = 1'b0;
      codes.delete();
      exp_q.delete();
      exp_err = 0;
      idle(2);
      check("rst_m_valid", FW'(m_valid), FW'(0));
      rst_n = 1'b1;
      m_ready = 1'b1;
      p0 = pops;
      for (int b = 0; b < BEATS; b++) send_beat(BW'($urandom), b == BEATS - 1);
      idle(2);
      check("rst_one_frame", FW'(pops - p0), FW'(1));

      // Randomized traffic: gaps, random m_ready, occasional framing faults.
      rand_mode = 1;
      for (int f = 0; f < 40; f++) begin
         for (int b = 0; b < BEATS; b++) begin
            bit last;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            last = (b == BEATS - 1);
            if ($urandom_range(0, 15) == 0) last = !last;
            send_beat(BW'($urandom), last);
         end
      end
      rand_mode = 0;
      m_ready = 1'b1;
      flush_partial();
      w = 0;
      while (exp_q.size() != 0 && w < 50) begin
         idle(1);
         w++;
      end
      check("final_drain", FW'(exp_q.size()), FW'(0));
      check("final_err", FW'(err), FW'(exp_err));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
